// File: rtl/clk_divider.sv
// rtl/clk_divider.sv - synchronous integer clock divider with glitch-free clk_out and period tick
//
// Optional runtime divisor update is built when DIVIDER_RUNTIME_EN is defined;
// otherwise the divide ratio is the constant DIV_VALUE (clamped to at least 2).

module clk_divider #(
  parameter int DIV_VALUE = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
`ifdef DIVIDER_RUNTIME_EN
  input  logic [CNT_W-1:0] div_in_i,
  input  logic             div_load_i,
`endif
  output logic             clk_out_o,
  output logic             tick_o
);

  // Ratios below 2 cannot form a low and a high phase, so they collapse to 2.
  localparam int               DIV_CLAMP = (DIV_VALUE < 2) ? 2 : DIV_VALUE;
  localparam logic [CNT_W-1:0] N_RST     = CNT_W'(DIV_CLAMP);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] n_act;
  logic [CNT_W-1:0] high_start;
  logic             wrap;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  // The last count of the period; the next enabled edge starts a new period.
  assign wrap     = (cnt_q == n_act - ONE);
  assign cnt_next = wrap ? '0 : cnt_q + ONE;

  // High phase covers the final floor(N/2) counts, so odd N is low-biased.
  assign high_start = n_act - (n_act >> 1);

`ifdef DIVIDER_RUNTIME_EN
  logic [CNT_W-1:0] n_act_q, n_act_d;
  logic [CNT_W-1:0] n_pend_q, n_pend_d;
  logic [CNT_W-1:0] div_clamped;

  assign div_clamped = (div_in_i < TWO) ? TWO : div_in_i;
  assign n_act       = n_act_q;

  // A new ratio is staged in n_pend and only promoted at a wrap, so no period is cut short;
  // a load coinciding with the wrap bypasses the stage and governs the period starting there.
  always_comb begin
    n_pend_d = n_pend_q;
    n_act_d  = n_act_q;
    if (div_load_i) begin
      n_pend_d = div_clamped;
    end
    if (en_i && wrap) begin
      n_act_d = div_load_i ? div_clamped : n_pend_q;
    end
  end

  // Divisor registers; loads are accepted regardless of en_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      n_act_q  <= N_RST;
      n_pend_q <= N_RST;
    end else begin
      n_act_q  <= n_act_d;
      n_pend_q <= n_pend_d;
    end
  end
`else
  assign n_act = N_RST;
`endif

  // Advance the phase only when enabled; clk_out holds and tick drops while paused.
  always_comb begin
    cnt_d     = cnt_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    if (en_i) begin
      cnt_d     = cnt_next;
      clk_out_d = (cnt_next >= high_start);
      tick_d    = (cnt_next == '0);
    end
  end

  // Phase counter and registered outputs; reset aborts any period in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;

endmodule

// File: tb/tb_clk_divider.sv
// tb/tb_clk_divider.sv - scoreboard bench for clk_divider (N=4, N=3, DIV_VALUE=1 instances)

module tb_clk_divider;

`ifdef DIVIDER_RUNTIME_EN
  localparam bit RT = 1'b1;
`else
  localparam bit RT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        div_load = 1'b0;
  logic [15:0] div_in = '0;
  logic        co4, co3, co2, tk4, tk3, tk2;

  always #5 clk = ~clk;

  clk_divider #(.DIV_VALUE(4), .CNT_W(16)) u4 (
    .clk_i(clk), .rst_i(rst), .en_i(en),
`ifdef DIVIDER_RUNTIME_EN
    .div_in_i(div_in), .div_load_i(div_load),
`endif
    .clk_out_o(co4), .tick_o(tk4));

  clk_divider #(.DIV_VALUE(3), .CNT_W(16)) u3 (
    .clk_i(clk), .rst_i(rst), .en_i(en),
`ifdef DIVIDER_RUNTIME_EN
    .div_in_i(div_in), .div_load_i(div_load),
`endif
    .clk_out_o(co3), .tick_o(tk3));

  clk_divider #(.DIV_VALUE(1), .CNT_W(16)) u2 (
    .clk_i(clk), .rst_i(rst), .en_i(en),
`ifdef DIVIDER_RUNTIME_EN
    .div_in_i(div_in), .div_load_i(div_load),
`endif
    .clk_out_o(co2), .tick_o(tk2));

  typedef struct {
    int         cyc;
    logic [2:0] c;
    logic [2:0] t;
  } exp_t;

  exp_t     exp_q[$];
  bit [1:0] wave[3][$];
  int       pend[3];
  logic     last_clk[3];
  int       n0[3] = '{4, 3, 2};
  string    nm[3] = '{"N4", "N3", "N2"};
  int       tests = 0;
  int       fails = 0;
  int       cycle = 0;

  // One output period of ratio n as {clk_out, tick} per enabled edge, starting at the wrap edge.
  task automatic build(input int i, input int n);
    for (int j = 0; j < n; j++) begin
      wave[i].push_back({(j >= (n + 1) / 2) ? 1'b1 : 1'b0, (j == 0) ? 1'b1 : 1'b0});
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit ld, input logic [15:0] dv);
    exp_t x;
    int   ldn;
    ldn = (dv < 16'd2) ? 2 : int'(dv);
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        wave[i].delete();
        build(i, n0[i]);
        void'(wave[i].pop_front());
        pend[i]     = n0[i];
        last_clk[i] = 1'b0;
        x.c[i]      = 1'b0;
        x.t[i]      = 1'b0;
      end else begin
        if (e) begin
          if (wave[i].size() == 0) build(i, (RT && ld) ? ldn : pend[i]);
          {x.c[i], x.t[i]} = wave[i].pop_front();
          last_clk[i]      = x.c[i];
        end else begin
          x.c[i] = last_clk[i];
          x.t[i] = 1'b0;
        end
        if (RT && ld) pend[i] = ldn;
      end
    end
    x.cyc = cycle;
    exp_q.push_back(x);
  endtask

  task automatic cyc(input bit r, input bit e, input bit ld, input int dv);
    @(negedge clk);
    cycle    = cycle + 1;
    rst      = r;
    en       = e;
    div_load = ld;
    div_in   = 16'(dv);
    model_step(rst, en, div_load, div_in);
  endtask

  // Monitor: every clock edge yields an output sample, compared against the oldest prediction.
  initial begin
    exp_t       x;
    logic [2:0] ac, at;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x  = exp_q.pop_front();
        ac = {co2, co3, co4};
        at = {tk2, tk3, tk4};
        for (int i = 0; i < 3; i++) begin
          tests++;
          if (ac[i] !== x.c[i]) begin
            fails++;
            $display("FAIL clk_out_%s cyc=%0d got=%b exp=%b", nm[i], x.cyc, ac[i], x.c[i]);
          end
          tests++;
          if (at[i] !== x.t[i]) begin
            fails++;
            $display("FAIL tick_%s cyc=%0d got=%b exp=%b", nm[i], x.cyc, at[i], x.t[i]);
          end
        end
      end
    end
  end

  initial begin
    // Reset held two cycles, then free-running.
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    repeat (40) cyc(0, 1, 0, 0);

    // Pause in the high phase of the N=4 divider.
    for (int k = 0; k < 20 && wave[0].size() != 1; k++) cyc(0, 1, 0, 0);
    repeat (5) cyc(0, 0, 0, 0);
    repeat (10) cyc(0, 1, 0, 0);

    // Reset at cnt=2 of the N=4 divider.
    for (int k = 0; k < 20 && wave[0].size() != 1; k++) cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    repeat (12) cyc(0, 1, 0, 0);

    // Runtime ratio changes (no effect on outputs in the fixed build).
    cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 6);
    repeat (24) cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    repeat (16) cyc(0, 1, 0, 0);
    for (int k = 0; k < 30 && wave[0].size() != 0; k++) cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 8);
    repeat (20) cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 3);
    repeat (12) cyc(0, 1, 0, 0);

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0),
          ($urandom_range(0, 19) == 0), int'($urandom_range(0, 9)));
    end
    cyc(0, 1, 0, 0);

    @(posedge clk);
    #3;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
